// File: rtl/siso_johnson_banks.sv
// Banked SISO delay line: DIN reappears on D_OUT 8*BANK_DEPTH enabled cycles later.
// Latency: D_OUT registered; DIN of enabled cycle n appears after enabled edge n+DLY.
// Backpressure: SHIFT_EN low freezes all state; PULSES is zero while stalled.
module siso_johnson_banks #(
    parameter int BANK_DEPTH = 4,
    parameter int CNT_W      = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SHIFT_EN,
    input  logic       DIN,
    output logic       D_OUT,
    output logic [3:0] JOHNSON,
    output logic [7:0] PULSES,
    output logic       PRIMED
);

    localparam int DLY = 8 * BANK_DEPTH;

    logic [3:0]            j_q;
    logic [BANK_DEPTH-1:0] bank_q [8];
    logic [CNT_W-1:0]      fill_q;
    logic                  primed_q;
    logic                  d_out_q;
    logic                  j_legal;
    logic [2:0]            bank_idx;

    // Decode the Johnson state into a bank index; the 8 unused codes are illegal.
    always_comb begin
        j_legal  = 1'b1;
        bank_idx = 3'd0;
        case (j_q)
            4'b0000: bank_idx = 3'd0;
            4'b0001: bank_idx = 3'd1;
            4'b0011: bank_idx = 3'd2;
            4'b0111: bank_idx = 3'd3;
            4'b1111: bank_idx = 3'd4;
            4'b1110: bank_idx = 3'd5;
            4'b1100: bank_idx = 3'd6;
            4'b1000: bank_idx = 3'd7;
            default: j_legal  = 1'b0;
        endcase
    end

    // One-hot write strobe for the bank accessed this cycle.
    always_comb begin
        PULSES = 8'h00;
        if (SHIFT_EN && j_legal) begin
            PULSES[bank_idx] = 1'b1;
        end
    end

    // Johnson counter: advance on enable, self-heal from illegal codes unconditionally.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            j_q <= 4'b0000;
        end else if (!j_legal) begin
            j_q <= 4'b0000;
        end else if (SHIFT_EN) begin
            j_q <= {j_q[2:0], ~j_q[3]};
        end
    end

    // Only the selected bank shifts; its oldest bit becomes the output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
            d_out_q <= 1'b0;
        end else if (SHIFT_EN && j_legal) begin
            bank_q[bank_idx] <= {bank_q[bank_idx][BANK_DEPTH-2:0], DIN};
            d_out_q          <= bank_q[bank_idx][BANK_DEPTH-1];
        end
    end

    // Saturating fill counter; PRIMED registers the compare so it rises with the first real data bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else if (SHIFT_EN) begin
            if (fill_q != CNT_W'(DLY)) begin
                fill_q <= fill_q + CNT_W'(1);
            end
            primed_q <= (fill_q == CNT_W'(DLY));
        end
    end

    assign D_OUT   = d_out_q;
    assign JOHNSON = j_q;
    assign PRIMED  = primed_q;

endmodule
